cpub_rst_seq: RTL and testbench
===============================

Name: cpub_rst_seq

Overview:
Reset-release sequencer for the CPUB (Cortex-A5 cluster) subsystem. It sits directly upstream of the CPUB CRU wrapper and drives the per-domain soft-reset controls consumed by that wrapper (pd_cpub_srst_con field layout).
- After chip reset it releases SCU/peripheral, debug, core and watchdog resets in a fixed order with programmable spacing.
- In run mode it services per-core software reset requests. Each request waits for the core to reach WFI, or for a timeout, before the core reset is pulsed.

Parameters:
NCORE, 4, number of A5 cores (1..4)
CNT_W, 8, width of step/hold counters
WFI_TO, 1024, cycles to wait for standbywfi before forced reset
TO_W, 11, width of WFI timeout counter (must hold WFI_TO)

Ports:
clk_cpub  in  1  CPUB bus clock, free-running
chiprstn  in  1  asynchronous active-low reset; synchronous deassertion is handled upstream
soc_scan_mode  in  1  1 = all reset outputs follow chiprstn directly, FSMs frozen
step_cyc  in  CNT_W  spacing between release stages; 0 is treated as 1
hold_cyc  in  CNT_W  core reset pulse width for software reset; 0 is treated as 1
core_boot_en  in  NCORE  cores released at boot; core0 is always released
core_rst_req  in  NCORE  per-core software reset request, level, sampled in DONE only
standbywfi  in  NCORE  core in WFI
srst_scu_n  out  1  SCU reset, active-low
srst_periph_n  out  1  periph/GIC/timer reset, active-low
srst_dbg_n  out  NCORE  per-core debug reset
srst_core_n  out  NCORE  per-core CPU reset
srst_wd_n  out  NCORE  per-core watchdog reset
seq_done  out  1  boot sequence complete
core_rst_ack  out  NCORE  one-cycle pulse, software reset finished
core_rst_to  out  NCORE  sticky flag, last software reset was forced by timeout; cleared on next request accept

Behaviour:
Reset values (chiprstn=0): all srst_*_n = 0, seq_done = 0, core_rst_ack = 0, core_rst_to = 0, FSMs in S_RST, counters = 0.

Main FSM (state, then action and transition):
- S_RST: after the first clock edge with chiprstn=1, go to S_SCU and load step_cnt.
- S_SCU: when step_cnt hits eff_step, assert srst_scu_n=1 and srst_periph_n=1 together, then go to S_DBG.
- S_DBG: after eff_step cycles, set srst_dbg_n to all ones, then go to S_CORE.
- S_CORE: releases srst_core_n[i] and srst_wd_n[i] together.
  - Order is i = 0, 1, ..., NCORE-1, one core per eff_step interval.
  - Cores with core_boot_en[i]=0 (i>0) are skipped with zero delay; their core/wd resets stay 0.
- S_DONE: after the last candidate core, seq_done=1. Stays here until chiprstn.

Spacing rules:
- eff_step = (step_cyc==0) ? 1 : step_cyc.
- step_cyc is sampled at each stage start; changing it mid-stage has no effect on the current stage.
- Boot latency with all cores enabled and step=N: SCU release at N cycles after reset deassert, debug at 2N, core i at (3+i)N, seq_done 1 cycle after the last core release.

Per-core software reset FSM (one per core, active only in S_DONE):
- IDLE: on core_rst_req[i]=1, clear core_rst_to[i], go to WAITWFI, load to_cnt.
- WAITWFI: when standbywfi[i]=1, go to HOLD. If to_cnt reaches WFI_TO first, set core_rst_to[i]=1 and go to HOLD. If both occur in the same cycle, WFI wins (to flag not set).
- HOLD: srst_core_n[i]=0 and srst_wd_n[i]=0 for eff_hold cycles. Debug reset is untouched.
- REL: release resets, pulse core_rst_ack[i] for 1 cycle, return to IDLE. A request still high in IDLE the next cycle starts a new cycle.

Additional rules:
- Requests to a core not released at boot (core_boot_en=0) are accepted and release that core. This is the secondary-core bring-up path.
- A request arriving before S_DONE is ignored; it is not queued.
- chiprstn assertion at any point asynchronously forces the reset values above, including mid-HOLD.
- soc_scan_mode=1: every srst_*_n output = chiprstn. Counters and FSMs hold their state.
- All outputs are registered. No combinational path from inputs to outputs except the scan bypass mux.

Decomposition:
- Package cpub_rst_pkg: main FSM enum (S_RST, S_SCU, S_DBG, S_CORE, S_DONE), per-core enum (C_IDLE, C_WAITWFI, C_HOLD, C_REL), and the bit-index constants that map outputs onto pd_cpub_srst_con fields.
- Sub-module cpub_core_rst_ctl: per-core FSM with hold and timeout counters, instantiated NCORE times by generate.

Test Plan:
- Boot: step_cyc=4, core_boot_en=4'b1111 → scu/periph release @4, dbg @8, core0..3 @12/16/20/24, seq_done @25.
- Skipped cores: core_boot_en=4'b0101, step_cyc=0 → releases every 1 cycle; core1/core3 resets stay 0; seq_done after core2.
- Software reset with WFI: core_rst_req[1] pulse, standbywfi[1] high 5 cycles later, hold_cyc=3 → srst_core_n[1] low exactly 3 cycles; ack pulse 1 cycle; core_rst_to[1]=0.
- Timeout: core_rst_req[2] with standbywfi[2]=0 → forced hold after 1024 cycles; core_rst_to[2]=1 until the next request.
- Reset mid-operation: drop chiprstn during HOLD → all outputs 0 immediately. Raise chiprstn → full boot sequence restarts.
- Scan bypass: soc_scan_mode=1, toggle chiprstn → all srst_*_n track chiprstn. Clear scan_mode → FSM resumes from its frozen state.

Source files
------------

// File: rtl/cpub_rst_pkg.sv
// Shared types and pd_cpub_srst_con field positions for the CPUB reset-release sequencer.
package cpub_rst_pkg;

  typedef enum logic [2:0] {S_RST, S_SCU, S_DBG, S_CORE, S_DONE} main_st_e;
  typedef enum logic [1:0] {C_IDLE, C_WAITWFI, C_HOLD, C_REL} core_st_e;

  // Bit positions inside pd_cpub_srst_con (field layout fixed for up to 4 cores)
  localparam int SRST_SCU_BIT    = 0;
  localparam int SRST_PERIPH_BIT = 1;
  localparam int SRST_DBG_LSB    = 2;
  localparam int SRST_CORE_LSB   = 6;
  localparam int SRST_WD_LSB     = 10;
  localparam int SRST_CON_W      = 14;

endpackage

// File: rtl/cpub_core_rst_ctl.sv
// Per-core software reset controller: waits for WFI (or timeout), then pulses the core/wd reset.
module cpub_core_rst_ctl
  import cpub_rst_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int WFI_TO = 1024,
  parameter int TO_W   = 11
) (
  input  logic             clk_cpub,
  input  logic             chiprstn,
  input  logic             frz,
  input  logic             active,
  input  logic             boot_rel,
  input  logic [CNT_W-1:0] hold_cyc,
  input  logic             req,
  input  logic             wfi,
  output logic             core_n,
  output logic             ack,
  output logic             to_flag
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(WFI_TO - 1);

  core_st_e         st_q, st_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d, hold_eff_q, hold_eff_d;
  logic             rel_q, rel_d, ack_q, ack_d, to_q, to_d;

  always_comb begin
    st_d       = st_q;
    to_cnt_d   = to_cnt_q;
    hold_cnt_d = hold_cnt_q;
    hold_eff_d = hold_eff_q;
    rel_d      = rel_q;
    ack_d      = 1'b0;
    to_d       = to_q;
    if (boot_rel) rel_d = 1'b1;
    case (st_q)
      C_IDLE: if (active && req) begin
        st_d     = C_WAITWFI;
        to_d     = 1'b0;
        to_cnt_d = '0;
      end
      // WFI has priority over a timeout landing on the same cycle
      C_WAITWFI: if (wfi || to_cnt_q == TO_LAST) begin
        st_d       = C_HOLD;
        to_d       = !wfi;
        rel_d      = 1'b0;
        hold_cnt_d = '0;
        hold_eff_d = (hold_cyc == '0) ? CNT_W'(1) : hold_cyc;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
      C_HOLD: if (hold_cnt_q == hold_eff_q - 1'b1) begin
        st_d  = C_REL;
        rel_d = 1'b1;
        ack_d = 1'b1;
      end else begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
      C_REL:   st_d = C_IDLE;
      default: st_d = C_IDLE;
    endcase
  end

  always_ff @(posedge clk_cpub or negedge chiprstn) begin
    if (!chiprstn) begin
      st_q       <= C_IDLE;
      to_cnt_q   <= '0;
      hold_cnt_q <= '0;
      hold_eff_q <= '0;
      rel_q      <= 1'b0;
      ack_q      <= 1'b0;
      to_q       <= 1'b0;
    end else if (!frz) begin
      st_q       <= st_d;
      to_cnt_q   <= to_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      hold_eff_q <= hold_eff_d;
      rel_q      <= rel_d;
      ack_q      <= ack_d;
      to_q       <= to_d;
    end
  end

  assign core_n  = rel_q;
  assign ack     = ack_q;
  assign to_flag = to_q;

endmodule

// File: rtl/cpub_rst_seq.sv
// CPUB reset-release sequencer: ordered boot release of SCU/debug/cores, then per-core soft resets.
module cpub_rst_seq
  import cpub_rst_pkg::*;
#(
  parameter int NCORE  = 4,
  parameter int CNT_W  = 8,
  parameter int WFI_TO = 1024,
  parameter int TO_W   = 11
) (
  input  logic             clk_cpub,
  input  logic             chiprstn,
  input  logic             soc_scan_mode,
  input  logic [CNT_W-1:0] step_cyc,
  input  logic [CNT_W-1:0] hold_cyc,
  input  logic [NCORE-1:0] core_boot_en,
  input  logic [NCORE-1:0] core_rst_req,
  input  logic [NCORE-1:0] standbywfi,
  output logic             srst_scu_n,
  output logic             srst_periph_n,
  output logic [NCORE-1:0] srst_dbg_n,
  output logic [NCORE-1:0] srst_core_n,
  output logic [NCORE-1:0] srst_wd_n,
  output logic             seq_done,
  output logic [NCORE-1:0] core_rst_ack,
  output logic [NCORE-1:0] core_rst_to
);

  localparam int IDX_W = (NCORE > 1) ? $clog2(NCORE) : 1;

  main_st_e         st_q, st_d;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d, step_eff_q, step_eff_d, eff_step;
  logic [IDX_W-1:0] idx_q, idx_d, nxt_idx;
  logic             nxt_vld, step_hit, scu_q, scu_d, done_q, done_d;
  logic [NCORE-1:0] dbg_q, dbg_d, boot_rel, core_n;
  logic [SRST_CON_W-1:0] srst_con, srst_out;

  assign eff_step = (step_cyc == '0) ? CNT_W'(1) : step_cyc;
  assign step_hit = (step_cnt_q == step_eff_q - 1'b1);

  // Lowest boot-enabled core above the current one; disabled cores cost no time
  always_comb begin
    nxt_vld = 1'b0;
    nxt_idx = '0;
    for (int i = NCORE - 1; i >= 0; i--) begin
      if ((core_boot_en[i] || i == 0) && i > int'(idx_q)) begin
        nxt_vld = 1'b1;
        nxt_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    st_d       = st_q;
    step_cnt_d = step_cnt_q;
    step_eff_d = step_eff_q;
    idx_d      = idx_q;
    scu_d      = scu_q;
    dbg_d      = dbg_q;
    done_d     = done_q;
    case (st_q)
      S_RST: begin
        st_d       = S_SCU;
        step_cnt_d = '0;
        step_eff_d = eff_step;
      end
      S_SCU, S_DBG, S_CORE: if (step_hit) begin
        step_cnt_d = '0;
        step_eff_d = eff_step;
        if (st_q == S_SCU) begin
          scu_d = 1'b1;
          st_d  = S_DBG;
        end else if (st_q == S_DBG) begin
          dbg_d = '1;
          st_d  = S_CORE;
          idx_d = '0;
        end else if (nxt_vld) begin
          idx_d = nxt_idx;
        end else begin
          st_d = S_DONE;
        end
      end else begin
        step_cnt_d = step_cnt_q + 1'b1;
      end
      S_DONE:  done_d = 1'b1;
      default: st_d = S_RST;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NCORE; i++)
      boot_rel[i] = (st_q == S_CORE) && step_hit && (int'(idx_q) == i);
  end

  always_ff @(posedge clk_cpub or negedge chiprstn) begin
    if (!chiprstn) begin
      st_q       <= S_RST;
      step_cnt_q <= '0;
      step_eff_q <= '0;
      idx_q      <= '0;
      scu_q      <= 1'b0;
      dbg_q      <= '0;
      done_q     <= 1'b0;
    end else if (!soc_scan_mode) begin
      st_q       <= st_d;
      step_cnt_q <= step_cnt_d;
      step_eff_q <= step_eff_d;
      idx_q      <= idx_d;
      scu_q      <= scu_d;
      dbg_q      <= dbg_d;
      done_q     <= done_d;
    end
  end

  for (genvar i = 0; i < NCORE; i++) begin : g_core
    cpub_core_rst_ctl #(.CNT_W(CNT_W), .WFI_TO(WFI_TO), .TO_W(TO_W)) u_ctl (
      .clk_cpub (clk_cpub),
      .chiprstn (chiprstn),
      .frz      (soc_scan_mode),
      .active   (st_q == S_DONE),
      .boot_rel (boot_rel[i]),
      .hold_cyc (hold_cyc),
      .req      (core_rst_req[i]),
      .wfi      (standbywfi[i]),
      .core_n   (core_n[i]),
      .ack      (core_rst_ack[i]),
      .to_flag  (core_rst_to[i])
    );
  end

  always_comb begin
    srst_con                               = '0;
    srst_con[SRST_SCU_BIT]                 = scu_q;
    srst_con[SRST_PERIPH_BIT]              = scu_q;
    srst_con[SRST_DBG_LSB  +: NCORE]       = dbg_q;
    srst_con[SRST_CORE_LSB +: NCORE]       = core_n;
    srst_con[SRST_WD_LSB   +: NCORE]       = core_n;
  end

  // Scan bypass is the only combinational input-to-output path
  assign srst_out      = soc_scan_mode ? {SRST_CON_W{chiprstn}} : srst_con;
  assign srst_scu_n    = srst_out[SRST_SCU_BIT];
  assign srst_periph_n = srst_out[SRST_PERIPH_BIT];
  assign srst_dbg_n    = srst_out[SRST_DBG_LSB  +: NCORE];
  assign srst_core_n   = srst_out[SRST_CORE_LSB +: NCORE];
  assign srst_wd_n     = srst_out[SRST_WD_LSB   +: NCORE];
  assign seq_done      = done_q;

endmodule

// File: tb/tb_cpub_rst_seq.sv
// Bench for cpub_rst_seq: timestamp-based reference model checked every cycle plus directed literals.
module tb_cpub_rst_seq;

  localparam int NC = 4;
  localparam int TO = 1024;

  logic          clk = 1'b0, chiprstn = 1'b1, soc_scan_mode = 1'b0;
  logic [7:0]    step_cyc = 8'd4, hold_cyc = 8'd3;
  logic [NC-1:0] core_boot_en = '1, core_rst_req = '0, standbywfi = '0;
  logic          srst_scu_n, srst_periph_n, seq_done;
  logic [NC-1:0] srst_dbg_n, srst_core_n, srst_wd_n, core_rst_ack, core_rst_to;

  cpub_rst_seq #(.NCORE(NC), .CNT_W(8), .WFI_TO(TO), .TO_W(11)) dut (
    .clk_cpub(clk), .chiprstn(chiprstn), .soc_scan_mode(soc_scan_mode),
    .step_cyc(step_cyc), .hold_cyc(hold_cyc), .core_boot_en(core_boot_en),
    .core_rst_req(core_rst_req), .standbywfi(standbywfi),
    .srst_scu_n(srst_scu_n), .srst_periph_n(srst_periph_n), .srst_dbg_n(srst_dbg_n),
    .srst_core_n(srst_core_n), .srst_wd_n(srst_wd_n), .seq_done(seq_done),
    .core_rst_ack(core_rst_ack), .core_rst_to(core_rst_to)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: boot releases are scheduled as absolute times from the first active edge
  bit            started = 0, m_scu = 0, m_done = 0;
  int            t = 0, n_step = 1, done_t = 0;
  int            boot_t[NC];
  logic [NC-1:0] m_dbg = '0, m_core = '0, m_ack = '0, m_to = '0;
  bit            busy[NC];
  int            acc_t[NC], hold_t[NC], hlen[NC], rel_t[NC];

  always @(posedge clk or negedge chiprstn) begin
    if (!chiprstn) begin
      started = 0; t = 0; m_scu = 0; m_done = 0;
      m_dbg = '0; m_core = '0; m_ack = '0; m_to = '0;
      for (int i = 0; i < NC; i++) busy[i] = 0;
    end else if (!soc_scan_mode) begin
      if (!started) begin
        int k;
        started = 1; t = 0; k = 0;
        n_step = (step_cyc == 0) ? 1 : int'(step_cyc);
        for (int i = 0; i < NC; i++) begin
          if (i == 0 || core_boot_en[i]) begin
            boot_t[i] = (3 + k) * n_step;
            done_t    = boot_t[i] + 1;
            k++;
          end else boot_t[i] = -1;
        end
      end else t++;
      m_scu  = (t >= n_step);
      m_dbg  = (t >= 2 * n_step) ? '1 : '0;
      m_done = (t >= done_t);
      for (int i = 0; i < NC; i++) begin
        if (t == boot_t[i]) m_core[i] = 1'b1;
        if (t >= done_t) begin
          m_ack[i] = 1'b0;
          if (!busy[i]) begin
            if (core_rst_req[i]) begin
              busy[i] = 1; acc_t[i] = t; hold_t[i] = -1; rel_t[i] = -1; m_to[i] = 1'b0;
            end
          end else if (rel_t[i] >= 0) begin
            busy[i] = 0;
          end else if (hold_t[i] < 0) begin
            if (standbywfi[i] || t - acc_t[i] == TO) begin
              hold_t[i] = t;
              hlen[i]   = (hold_cyc == 0) ? 1 : int'(hold_cyc);
              m_core[i] = 1'b0;
              m_to[i]   = !standbywfi[i];
            end
          end else if (t - hold_t[i] == hlen[i]) begin
            m_core[i] = 1'b1; m_ack[i] = 1'b1; rel_t[i] = t;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("scu",    srst_scu_n,    soc_scan_mode ? chiprstn : m_scu);
      chk("periph", srst_periph_n, soc_scan_mode ? chiprstn : m_scu);
      chk("dbg",    srst_dbg_n,    soc_scan_mode ? {NC{chiprstn}} : m_dbg);
      chk("core",   srst_core_n,   soc_scan_mode ? {NC{chiprstn}} : m_core);
      chk("wd",     srst_wd_n,     soc_scan_mode ? {NC{chiprstn}} : m_core);
      chk("done",   seq_done,      m_done);
      chk("ack",    core_rst_ack,  m_ack);
      chk("to",     core_rst_to,   m_to);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic do_reset();
    chiprstn = 1'b0; core_rst_req = '0; standbywfi = '0;
    tick(2);
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!seq_done && n < 400) begin tick(); n++; end
    chk(nm, seq_done, 1'b1);
  endtask

  task automatic random_traffic(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < NC; i++) core_rst_req[i] = ($urandom_range(7) == 0);
      standbywfi = NC'($urandom);
      if ($urandom_range(15) == 0) hold_cyc = 8'($urandom_range(4));
      tick();
    end
    core_rst_req = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout @%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int n, lo, acks;
    tick();
    chiprstn = 1'b0;
    #1 chk_en = 1;
    tick(3);
    chk("rst_core", srst_core_n, 4'h0);
    chk("rst_done", seq_done, 1'b0);

    // Boot, step 4, all cores
    step_cyc = 8'd4; core_boot_en = 4'b1111; hold_cyc = 8'd3;
    chiprstn = 1'b1;
    tick(4); chk("boot_scu_t3", srst_scu_n, 1'b0);
    tick();  chk("boot_scu_t4", srst_scu_n, 1'b1);
    tick(19); chk("boot_core_t23", srst_core_n, 4'b0111);
    tick();  chk("boot_core_t24", srst_core_n, 4'b1111);
    chk("boot_done_t24", seq_done, 1'b0);
    tick();  chk("boot_done_t25", seq_done, 1'b1);

    // Soft reset of core1 with WFI 5 cycles after request
    core_rst_req[1] = 1'b1; tick(); core_rst_req[1] = 1'b0;
    tick(4); standbywfi[1] = 1'b1;
    lo = 0; acks = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (!srst_core_n[1]) lo++;
      if (core_rst_ack[1]) acks++;
    end
    chk("wfi_low_cycles", lo, 3);
    chk("wfi_ack_pulses", acks, 1);
    chk("wfi_to_flag", core_rst_to[1], 1'b0);
    standbywfi[1] = 1'b0;

    // Timeout on core2
    core_rst_req[2] = 1'b1; tick(); core_rst_req[2] = 1'b0;
    n = 0;
    while (srst_core_n[2] && n < 1100) begin tick(); n++; end
    chk("to_wait_cycles", n, 1024);
    tick(6);
    chk("to_flag_set", core_rst_to[2], 1'b1);
    chk("to_core_back", srst_core_n[2], 1'b1);
    standbywfi[2] = 1'b1; core_rst_req[2] = 1'b1; tick(); core_rst_req[2] = 1'b0;
    chk("to_flag_clear", core_rst_to[2], 1'b0);
    tick(10); standbywfi[2] = 1'b0;

    // Reset asserted mid-HOLD
    hold_cyc = 8'd8; standbywfi[0] = 1'b1; core_rst_req[0] = 1'b1;
    tick(); core_rst_req[0] = 1'b0; tick(2);
    chk("hold_core0_low", srst_core_n[0], 1'b0);
    chiprstn = 1'b0; #1;
    chk("midhold_outs", {srst_scu_n, srst_periph_n, srst_dbg_n, srst_core_n, srst_wd_n, seq_done}, 0);
    do_reset();

    // Skipped cores, step 0
    step_cyc = 8'd0; core_boot_en = 4'b0101; hold_cyc = 8'd2;
    chiprstn = 1'b1;
    tick(4); chk("skip_core_t3", srst_core_n, 4'b0001);
    tick();  chk("skip_core_t4", srst_core_n, 4'b0101);
    chk("skip_done_t4", seq_done, 1'b0);
    tick();  chk("skip_done_t5", seq_done, 1'b1);
    // Secondary bring-up of core3 via soft reset
    standbywfi[3] = 1'b1; core_rst_req[3] = 1'b1; tick(); core_rst_req[3] = 1'b0;
    tick(6); chk("bringup_core3", srst_core_n[3], 1'b1);
    do_reset();

    // Scan freeze mid-boot, then resume
    step_cyc = 8'd3; core_boot_en = 4'b1111; chiprstn = 1'b1;
    tick(5); soc_scan_mode = 1'b1; #1;
    chk("scan_hi_core", srst_core_n, 4'hF);
    tick(7); soc_scan_mode = 1'b0;
    wait_done("scan_resume_done");
    soc_scan_mode = 1'b1; chiprstn = 1'b0; #1;
    chk("scan_lo_all", {srst_scu_n, srst_dbg_n, srst_wd_n}, 0);
    tick(2); chiprstn = 1'b1; #1;
    chk("scan_hi_all", {srst_scu_n, srst_dbg_n, srst_wd_n}, 9'h1FF);
    tick(2); soc_scan_mode = 1'b0;
    wait_done("scan_reboot_done");

    // Randomized boots with requests during and after boot
    for (int it = 0; it < 6; it++) begin
      do_reset();
      step_cyc = 8'($urandom_range(5)); core_boot_en = NC'($urandom);
      hold_cyc = 8'($urandom_range(4)); chiprstn = 1'b1;
      for (int c = 0; c < 8; c++) begin
        core_rst_req = NC'($urandom); standbywfi = NC'($urandom); tick();
      end
      core_rst_req = '0;
      wait_done("rand_boot_done");
      random_traffic(250);
    end

    tick(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
